// File: rtl/bridge_pkg.sv
// ---------------------------------------------------------------------------
// bridge_pkg
//   Constants shared by the USB-to-HEEP bridge (bridge2xheep), its read-data
//   FIFO and the host register block.
//   - BRIDGE_DATA_W / BRIDGE_RDFIFO_DEPTH : default read-FIFO geometry.
//   - STAT_RDFIFO_* : bit positions of the read-FIFO flags inside the bridge
//     status register.
// ---------------------------------------------------------------------------
package bridge_pkg;

  localparam int BRIDGE_DATA_W       = 32;
  localparam int BRIDGE_RDFIFO_DEPTH = 8;

  localparam int STAT_RDFIFO_NEMPTY  = 0;
  localparam int STAT_RDFIFO_FULL    = 1;
  localparam int STAT_RDFIFO_OVF     = 2;
  localparam int STAT_RDFIFO_W       = 3;

  // Packs the read-FIFO flags into their status-register slice.
  function automatic logic [STAT_RDFIFO_W-1:0] rdfifo_status(
    input logic nempty,
    input logic full,
    input logic ovf
  );
    logic [STAT_RDFIFO_W-1:0] stat;
    stat                     = {STAT_RDFIFO_W{1'b0}};
    stat[STAT_RDFIFO_NEMPTY] = nempty;
    stat[STAT_RDFIFO_FULL]   = full;
    stat[STAT_RDFIFO_OVF]    = ovf;
    return stat;
  endfunction

endpackage

// File: rtl/bridge_rdata_fifo_mem.sv
// ---------------------------------------------------------------------------
// bridge_rdata_fifo_mem
//   pDEPTH x pDATA_WIDTH register array for the bridge read-data FIFO.
//   One synchronous write port, one asynchronous read port.
// Ports
//   clk       : heep_clk domain clock
//   rst_n     : async reset, active low (array cleared)
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_addr_i : read address
//   rd_data_o : read data (combinational from the array)
// ---------------------------------------------------------------------------
module bridge_rdata_fifo_mem #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 8,
  parameter int pPTR_WIDTH  = $clog2(pDEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [pPTR_WIDTH-1:0]  wr_addr_i,
  input  logic [pDATA_WIDTH-1:0] wr_data_i,
  input  logic [pPTR_WIDTH-1:0]  rd_addr_i,
  output logic [pDATA_WIDTH-1:0] rd_data_o
);

  logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];

  // Storage array: cleared on reset so the read port never shows X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < pDEPTH; i++) begin
        mem_q[i] <= {pDATA_WIDTH{1'b0}};
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/bridge_rdata_fifo.sv
// ---------------------------------------------------------------------------
// bridge_rdata_fifo
//   Show-ahead read-response FIFO downstream of the USB-to-HEEP bridge.
//   Captures every OBI read word (obi_rvalid_i/obi_rdata_i) and lets the host
//   register block drain them at USB pace. Reports level, full and a sticky
//   overflow flag for the bridge status register.
//
//   Optional feature macro: BRIDGE_RDFIFO_STATS_EN
//     defined   -> drop_count_o port + saturating 8-bit dropped-word counter
//     undefined -> no counter; overflow_o is the only loss indication
//
// Ports
//   clk          : heep_clk domain clock
//   rst_n        : async reset, active low
//   obi_rvalid_i : bridge read data valid (one pulse per word)
//   obi_rdata_i  : bridge read data
//   pop_i        : host consumed the head word
//   clear_i      : synchronous flush (wins over same-cycle push/pop)
//   head_data_o  : oldest stored word, 0 when empty
//   head_valid_o : FIFO non-empty
//   count_o      : number of stored words (0..pDEPTH)
//   full_o       : count_o == pDEPTH
//   overflow_o   : sticky, a word was dropped while full
//   drop_count_o : dropped-word counter (BRIDGE_RDFIFO_STATS_EN only)
// ---------------------------------------------------------------------------
module bridge_rdata_fifo
  import bridge_pkg::*;
#(
  parameter int pDATA_WIDTH = BRIDGE_DATA_W,
  parameter int pDEPTH      = BRIDGE_RDFIFO_DEPTH,
  parameter int pCNT_WIDTH  = $clog2(pDEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   obi_rvalid_i,
  input  logic [pDATA_WIDTH-1:0] obi_rdata_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  output logic [pDATA_WIDTH-1:0] head_data_o,
  output logic                   head_valid_o,
  output logic [pCNT_WIDTH-1:0]  count_o,
  output logic                   full_o,
  output logic                   overflow_o
`ifdef BRIDGE_RDFIFO_STATS_EN
  ,
  output logic [7:0]             drop_count_o
`endif
);

  localparam int                    PTR_W    = $clog2(pDEPTH);
  localparam logic [pCNT_WIDTH-1:0] CNT_FULL = pCNT_WIDTH'(pDEPTH);
  localparam logic [pCNT_WIDTH-1:0] CNT_ONE  = pCNT_WIDTH'(1);
  localparam logic [pCNT_WIDTH-1:0] CNT_ZERO = pCNT_WIDTH'(0);
  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0]      PTR_ZERO = PTR_W'(0);

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [pCNT_WIDTH-1:0]  count_q, count_d;
  logic                   overflow_q, overflow_d;

  logic                   empty_s;
  logic                   full_s;
  logic                   pop_acc_s;
  logic                   push_acc_s;
  logic                   drop_s;
  logic                   wr_en_s;
  logic [pDATA_WIDTH-1:0] rd_data_s;

  // count_q is the register of record; both flags are decoded from it.
  assign empty_s    = (count_q == CNT_ZERO);
  assign full_s     = (count_q == CNT_FULL);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  // a word when the host pops. An empty FIFO ignores the pop.
  assign pop_acc_s  = pop_i && !empty_s;
  assign push_acc_s = obi_rvalid_i && (!full_s || pop_acc_s);
  assign drop_s     = obi_rvalid_i && full_s && !pop_acc_s;
  assign wr_en_s    = push_acc_s && !clear_i;

  bridge_rdata_fifo_mem #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pDEPTH      (pDEPTH),
    .pPTR_WIDTH  (PTR_W)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (obi_rdata_i),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data_s)
  );

  // Next-state for pointers, level and sticky overflow; clear wins over all.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      wr_ptr_d   = PTR_ZERO;
      rd_ptr_d   = PTR_ZERO;
      count_d    = CNT_ZERO;
      overflow_d = 1'b0;
    end else begin
      if (push_acc_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_acc_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_acc_s, pop_acc_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (drop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // State registers for pointers, level and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef BRIDGE_RDFIFO_STATS_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating dropped-word counter; a drop coinciding with clear is not counted.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear_i) begin
      drop_cnt_d = 8'h00;
    end else if (drop_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'h01;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Dropped-word counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count_o = drop_cnt_q;
`endif

  assign count_o      = count_q;
  assign full_o       = full_s;
  assign head_valid_o = !empty_s;
  assign overflow_o   = overflow_q;
  assign head_data_o  = empty_s ? {pDATA_WIDTH{1'b0}} : rd_data_s;

endmodule

// File: tb/tb_bridge_rdata_fifo.sv
module tb_bridge_rdata_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          obi_rvalid;
  logic [DW-1:0] obi_rdata;
  logic          pop;
  logic          clear;
  logic [DW-1:0] head_data;
  logic          head_valid;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
`ifdef BRIDGE_RDFIFO_STATS_EN
  logic [7:0]    drop_count;
`endif

  bridge_rdata_fifo #(
    .pDATA_WIDTH (DW),
    .pDEPTH      (DEPTH),
    .pCNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .obi_rvalid_i (obi_rvalid),
    .obi_rdata_i  (obi_rdata),
    .pop_i        (pop),
    .clear_i      (clear),
    .head_data_o  (head_data),
    .head_valid_o (head_valid),
    .count_o      (count),
    .full_o       (full),
    .overflow_o   (overflow)
`ifdef BRIDGE_RDFIFO_STATS_EN
    ,
    .drop_count_o (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Scoreboard: words the FIFO should hold, oldest first.
  logic [DW-1:0] model_q[$];
  logic          m_ovf;
  int            m_drop;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          p;
    logic          c;
    int            exp_count;
    logic          exp_valid;
    logic [DW-1:0] exp_head;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_state();
    logic [DW-1:0] exp_head;
    int sz;
    sz = model_q.size();
    exp_head = (sz > 0) ? model_q[0] : 32'h0;
    chk("count", 32'(count), 32'(sz));
    chk("head_valid", 32'(head_valid), 32'(sz > 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("head_data", head_data, exp_head);
`ifdef BRIDGE_RDFIFO_STATS_EN
    chk("drop_count", 32'(drop_count), 32'(m_drop));
`endif
  endtask

  // Called #1 after a rising edge: drive one cycle, update model, check after edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic p, input logic c);
    logic pop_acc;
    logic [DW-1:0] exp_word;
    obi_rvalid = v;
    obi_rdata  = d;
    pop        = p;
    clear      = c;
    pop_acc = p && (model_q.size() > 0);
    if (c) begin
      model_q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (pop_acc) begin
        exp_word = model_q.pop_front();
        chk("pop_data", head_data, exp_word);
      end
      if (v) begin
        if (model_q.size() < DEPTH) begin
          model_q.push_back(d);
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
    obi_rvalid = 1'b0;
    obi_rdata  = 32'h0;
    pop        = 1'b0;
    clear      = 1'b0;
    check_state();
  endtask

  task automatic model_reset();
    model_q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  initial begin
    rst_n      = 1'b0;
    obi_rvalid = 1'b0;
    obi_rdata  = 32'h0;
    pop        = 1'b0;
    clear      = 1'b0;
    model_reset();

    // Tests 1 and 4 as a vector table with hand-computed expectations.
    vecs[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 1, 1'b1, 32'h11};
    vecs[1] = '{1'b1, 32'h22, 1'b0, 1'b0, 2, 1'b1, 32'h11};
    vecs[2] = '{1'b1, 32'h33, 1'b0, 1'b0, 3, 1'b1, 32'h11};
    vecs[3] = '{1'b0, 32'h00, 1'b1, 1'b0, 2, 1'b1, 32'h22};
    vecs[4] = '{1'b0, 32'h00, 1'b1, 1'b0, 1, 1'b1, 32'h33};
    vecs[5] = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 32'h00};
    vecs[6] = '{1'b1, 32'h5A, 1'b1, 1'b0, 1, 1'b1, 32'h5A};
    vecs[7] = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 32'h00};
    vecs[8] = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b0, 32'h00};

    #12;
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].p, vecs[i].c);
      chk("vec_count", 32'(count), 32'(vecs[i].exp_count));
      chk("vec_valid", 32'(head_valid), 32'(vecs[i].exp_valid));
      chk("vec_head", head_data, vecs[i].exp_head);
    end

    // Test 2: fill, then overflow with 0xDEAD, then drain.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    chk("t2_full", 32'(full), 32'h1);
    chk("t2_ovf", 32'(overflow), 32'h1);
    chk("t2_head", head_data, 32'h100);
`ifdef BRIDGE_RDFIFO_STATS_EN
    chk("t2_drop", 32'(drop_count), 32'h1);
`endif
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t2_empty", 32'(head_valid), 32'h0);

    // Test 3: full + push + pop in the same cycle.
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hBEEF, 1'b1, 1'b0);
    chk("t3_count", 32'(count), 32'(DEPTH));
    chk("t3_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t3_last", head_data, 32'hBEEF);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Test 5: 20 push/pop pairs across the pointer wrap.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'hA000 + 32'(i), 1'b0, 1'b0);
      chk("t5_head", head_data, 32'hA000 + 32'(i));
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("t5_cnt_le1", 32'(count <= 4'd1), 32'h1);
    end

    // Test 6: five words with overflow set, then clear with a same-cycle push.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t6_pre_count", 32'(count), 32'h5);
    chk("t6_pre_ovf", 32'(overflow), 32'h1);
    step(1'b1, 32'h77, 1'b0, 1'b1);
    chk("t6_count", 32'(count), 32'h0);
    chk("t6_ovf", 32'(overflow), 32'h0);
    chk("t6_valid", 32'(head_valid), 32'h0);
`ifdef BRIDGE_RDFIFO_STATS_EN
    chk("t6_drop", 32'(drop_count), 32'h0);
`endif

    // Asynchronous reset in the middle of a burst, away from any clock edge.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    obi_rvalid = 1'b1;
    obi_rdata  = 32'h999;
    rst_n      = 1'b0;
    #2;
    model_reset();
    check_state();
    obi_rvalid = 1'b0;
    obi_rdata  = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'h55, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
